// File: rtl/mmss_counter.sv
// mmss_counter: MM:SS BCD up/down counter with 1 Hz/2 Hz/500 Hz timebase and per-digit adjust
module mmss_counter #(
    parameter int CLK_FREQ = 100000000,
    parameter int MIN1_MAX = 5,
    parameter int MIN0_MAX = 9,
    parameter int SEC1_MAX = 5,
    parameter int SEC0_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       down,
    input  logic       adj,
    input  logic [1:0] sel,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic       tick_1hz,
    output logic       tick_2hz,
    output logic       tick_500hz,
    output logic       wrap
);
    localparam int W = $clog2(CLK_FREQ);
    localparam logic [W-1:0] P1_LAST = W'(CLK_FREQ - 1);
    localparam logic [W-1:0] P2_LAST = W'(CLK_FREQ / 2 - 1);
    localparam logic [W-1:0] P5_LAST = W'(CLK_FREQ / 500 - 1);
    localparam logic [3:0][3:0] MAXV = {4'(MIN1_MAX), 4'(MIN0_MAX), 4'(SEC1_MAX), 4'(SEC0_MAX)};
    logic [W-1:0] cnt_1, cnt_2, cnt_5;
    logic [3:0][3:0] d, d_nx;
    logic [4:0] cy;
    logic [3:0] stp;
    logic en, up;
    assign en = run && !adj;
    assign tick_1hz = cnt_1 == P1_LAST;
    assign tick_2hz = cnt_2 == P2_LAST;
    assign tick_500hz = cnt_5 == P5_LAST;
    assign {min1, min0, sec1, sec0} = d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_1 <= '0;
            cnt_2 <= '0;
            cnt_5 <= '0;
        end else begin
            if (en) begin
                cnt_1 <= tick_1hz ? '0 : cnt_1 + 1'b1;
                cnt_2 <= tick_2hz ? '0 : cnt_2 + 1'b1;
            end
            cnt_5 <= tick_500hz ? '0 : cnt_5 + 1'b1;
        end
    end
    // cy[k] requests a count-mode step of digit k; adjust mode only uses stp, so the chain stays idle
    always_comb begin
        d_nx = d;
        cy = '0;
        stp = '0;
        up = !down;
        if (adj) begin
            stp[sel] = inc ^ dec;
            up = inc;
        end else begin
            cy[0] = tick_1hz && run;
        end
        for (int k = 0; k < 4; k++) begin
            cy[k+1] = cy[k] && (up ? d[k] == MAXV[k] : d[k] == 4'd0);
            if (cy[k] || stp[k])
                d_nx[k] = up ? (d[k] == MAXV[k] ? 4'd0 : d[k] + 4'd1)
                             : (d[k] == 4'd0 ? MAXV[k] : d[k] - 4'd1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= '0;
            wrap <= 1'b0;
        end else begin
            d <= d_nx;
            wrap <= cy[4];
        end
    end
endmodule

// File: tb/tb_mmss_counter.sv
// tb_mmss_counter: randomized checks of mmss_counter against a seconds-based reference model
module tb_mmss_counter;
    localparam int F = 1000;
    logic clk = 0, rst = 1, run = 0, down = 0, adj = 0, inc = 0, dec = 0;
    logic [1:0] sel = 0;
    logic [3:0] sec0, sec1, min0, min1;
    logic tick_1hz, tick_2hz, tick_500hz, wrap;
    logic [19:0] obs;
    int checks = 0, errors = 0;
    int m_d[4], m_p1, m_p2, m_p5;
    bit m_wrap;
    int mx[4] = '{9, 5, 9, 5};

    mmss_counter #(.CLK_FREQ(F)) dut (
        .clk(clk), .rst(rst), .run(run), .down(down), .adj(adj), .sel(sel),
        .inc(inc), .dec(dec), .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_500hz(tick_500hz), .wrap(wrap)
    );

    assign obs = {min1, min0, sec1, sec0, tick_1hz, tick_2hz, tick_500hz, wrap};
    always #5 clk = ~clk;

    function automatic int secs();
        return m_d[3] * 600 + m_d[2] * 60 + m_d[1] * 10 + m_d[0];
    endfunction

    function automatic void set_secs(int t);
        m_d[3] = t / 600;
        m_d[2] = (t / 60) % 10;
        m_d[1] = (t % 60) / 10;
        m_d[0] = t % 10;
    endfunction

    function automatic logic [19:0] expv();
        return {4'(m_d[3]), 4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0]),
                m_p1 == F - 1, m_p2 == F / 2 - 1, m_p5 == F / 500 - 1, m_wrap};
    endfunction

    function automatic void model_reset();
        set_secs(0);
        m_p1 = 0;
        m_p2 = 0;
        m_p5 = 0;
        m_wrap = 0;
    endfunction

    // advance the model by one clock using the inputs currently driven, then sample after the edge
    task automatic cyc();
        bit en = run && !adj;
        int t = secs();
        m_wrap = 0;
        if (en && m_p1 == F - 1) begin
            m_wrap = down ? (t == 0) : (t == 3599);
            set_secs(down ? (t + 3599) % 3600 : (t + 1) % 3600);
        end
        if (adj && (inc ^ dec))
            m_d[sel] = inc ? (m_d[sel] + 1) % (mx[sel] + 1) : (m_d[sel] + mx[sel]) % (mx[sel] + 1);
        if (en) begin
            m_p1 = (m_p1 + 1) % F;
            m_p2 = (m_p2 + 1) % (F / 2);
        end
        m_p5 = (m_p5 + 1) % (F / 500);
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_tick(string tag);
        int b = secs();
        for (int n = 0; n <= F && secs() == b; n++) begin
            cyc();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL %s n=%0d got=%h want=%h", tag, n, obs, expv());
            end
        end
    endtask

    task automatic preload(int t);
        int tg[4];
        tg[0] = t % 10;
        tg[1] = (t % 60) / 10;
        tg[2] = (t / 60) % 10;
        tg[3] = t / 600;
        adj = 1;
        for (int k = 0; k < 4; k++) begin
            bit use_dec = 1'($urandom_range(0, 1));
            int n = use_dec ? (m_d[k] - tg[k] + mx[k] + 1) % (mx[k] + 1)
                            : (tg[k] - m_d[k] + mx[k] + 1) % (mx[k] + 1);
            sel = 2'(k);
            for (int j = 0; j < n; j++) begin
                inc = !use_dec;
                dec = use_dec;
                cyc();
            end
            inc = 0;
            dec = 0;
        end
        checks++;
        if (obs[19:4] !== {4'(tg[3]), 4'(tg[2]), 4'(tg[1]), 4'(tg[0])}) begin
            errors++;
            $display("FAIL preload got=%h want=%0d", obs[19:4], t);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_pulse got=%h want=0", obs);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        #3;
        model_reset();
        checks++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset got=%h want=0", obs);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_timebase();
        int n5 = 0, n2 = 0, n1 = 0;
        run = 1;
        down = 0;
        adj = 0;
        for (int i = 0; i < F; i++) begin
            cyc();
            n5 += int'(tick_500hz);
            n2 += int'(tick_2hz);
            n1 += int'(tick_1hz);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL timebase i=%0d got=%h want=%h", i, obs, expv());
            end
        end
        checks++;
        if ({n5, n2, n1} !== {32'd500, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL tick_counts got=%0d/%0d/%0d want=500/2/1", n5, n2, n1);
        end
        checks++;
        if (sec0 !== 4'd1) begin
            errors++;
            $display("FAIL first_second got=%0d want=1", sec0);
        end
    endtask

    task automatic test_preload_up();
        preload(59);
        adj = 0;
        run = 1;
        down = 0;
        run_to_tick("up_0059");
        checks++;
        if (obs[19:4] !== 16'h0100) begin
            errors++;
            $display("FAIL cascade_0100 got=%h want=0100", obs[19:4]);
        end
        preload(3599);
        adj = 0;
        run_to_tick("up_5959");
        checks++;
        if ({obs[19:4], wrap} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL wrap_up got=%h/%b want=0000/1", obs[19:4], wrap);
        end
        cyc();
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_width got=%b want=0", wrap);
        end
    endtask

    task automatic test_down();
        apply_reset();
        down = 1;
        run = 1;
        adj = 0;
        run_to_tick("down_0000");
        checks++;
        if ({obs[19:4], wrap} !== {16'h5959, 1'b1}) begin
            errors++;
            $display("FAIL wrap_down got=%h/%b want=5959/1", obs[19:4], wrap);
        end
        preload(600);
        adj = 0;
        run_to_tick("down_1000");
        checks++;
        if (obs[19:4] !== 16'h0959) begin
            errors++;
            $display("FAIL borrow_0959 got=%h want=0959", obs[19:4]);
        end
    endtask

    task automatic test_pause();
        int r = $urandom_range(1, F);
        int n5 = 0;
        run = 1;
        adj = 0;
        down = 1'($urandom_range(0, 1));
        for (int i = 0; i < r; i++) cyc();
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            n5 += int'(tick_500hz);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL pause i=%0d got=%h want=%h", i, obs, expv());
            end
        end
        checks++;
        if (n5 !== 1500) begin
            errors++;
            $display("FAIL pause_500hz got=%0d want=1500", n5);
        end
        run = 1;
        run_to_tick("pause_resume");
    endtask

    task automatic test_adjust();
        apply_reset();
        preload(50);
        sel = 2'b01;
        inc = 1;
        cyc();
        inc = 0;
        checks++;
        if ({obs[19:4], wrap} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL adj_inc got=%h/%b want=0000/0", obs[19:4], wrap);
        end
        dec = 1;
        cyc();
        dec = 0;
        checks++;
        if (obs[19:4] !== 16'h0050) begin
            errors++;
            $display("FAIL adj_dec got=%h want=0050", obs[19:4]);
        end
        inc = 1;
        dec = 1;
        cyc();
        inc = 0;
        dec = 0;
        checks++;
        if (obs[19:4] !== 16'h0050) begin
            errors++;
            $display("FAIL adj_both got=%h want=0050", obs[19:4]);
        end
        for (int i = 0; i < 300; i++) begin
            sel = 2'($urandom_range(0, 3));
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            down = 1'($urandom_range(0, 1));
            run = 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL adj_rand i=%0d got=%h want=%h", i, obs, expv());
            end
        end
        inc = 0;
        dec = 0;
        adj = 0;
    endtask

    task automatic test_async_reset();
        preload(754);
        adj = 0;
        run = 1;
        down = 0;
        for (int i = 0; i < int'($urandom_range(1, 20)); i++) cyc();
        @(negedge clk);
        #2;
        rst = 1;
        adj = 1;
        sel = 2'b00;
        inc = 1;
        model_reset();
        #1;
        checks++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", obs);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_hold got=%h want=0", obs);
        end
        @(negedge clk);
        rst = 0;
        adj = 0;
        inc = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL post_reset i=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            run = $urandom_range(0, 7) != 0;
            adj = $urandom_range(0, 15) == 0;
            sel = 2'($urandom_range(0, 3));
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) down = !down;
            cyc();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random i=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_timebase();
        test_preload_up();
        test_down();
        test_pause();
        test_adjust();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmss_counter.md
MMSS_COUNTER -- requirements
Module: mmss_counter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz; legal values are multiples of 500 and at least 1000.
REQ-002 SHALL have parameter MIN1_MAX, default 5, terminal value of the tens-of-minutes digit.
REQ-003 SHALL have parameters MIN0_MAX, SEC1_MAX and SEC0_MAX, defaults 9, 5 and 9 respectively, terminal values of those digits.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 run  input  1  1 = timebase advances; 0 = paused.
REQ-007 down  input  1  count direction for tick-driven stepping; 1 = down, 0 = up.
REQ-008 adj  input  1  1 = adjust mode.
REQ-009 sel  input  2  digit select in adjust mode: 00 sec0, 01 sec1, 10 min0, 11 min1.
REQ-010 inc  input  1  one-cycle increment request.
REQ-011 dec  input  1  one-cycle decrement request.
REQ-012 sec0, sec1, min0, min1  output  4 each  BCD digit values.
REQ-013 tick_1hz, tick_2hz, tick_500hz  output  1 each  one-cycle timebase pulses.
REQ-014 wrap  output  1  one-cycle pulse when min1 carries or borrows.

Function
REQ-015 Divider: three independent counters with periods CLK_FREQ, CLK_FREQ/2 and CLK_FREQ/500 cycles.
REQ-016 Each divider counter counts 0..P-1 and asserts its tick for exactly the cycle in which it holds P-1, then wraps to 0.
REQ-017 The 1 Hz and 2 Hz counters advance only when run=1 and adj=0; otherwise they hold their value.
REQ-018 The 500 Hz counter is free-running and is unaffected by run and adj.
REQ-019 Decade step, up: value==MAX -> 0 with carry asserted that cycle; otherwise value+1.
REQ-020 Decade step, down: value==0 -> MAX with carry (borrow) asserted that cycle; otherwise value-1.
REQ-021 Carry is combinational (step AND boundary), so a cascade such as 09:59 -> 10:00 completes in a single clock edge.
REQ-022 Count mode (adj=0): sec0 steps on tick_1hz in direction down; each digit's carry steps the next digit (sec0 -> sec1 -> min0 -> min1).
REQ-023 In count mode, wrap equals the min1 carry; the counter continues through 59:59 <-> 00:00.
REQ-024 In count mode, inc and dec are ignored.
REQ-025 Adjust mode (adj=1): inc steps the selected digit up and dec steps it down, irrespective of the down input.
REQ-026 Adjust steps do not propagate carry to other digits, and wrap stays 0.
REQ-027 Adjust mode: inc and dec asserted in the same cycle is a no-op.
REQ-028 Adjust mode: unselected digits hold.
REQ-029 Digit values are always within 0..MAX; no illegal BCD state is reachable.

Reset
REQ-030 While rst=1: all digits = 0, all divider counters = 0, all ticks = 0, wrap = 0; this takes effect immediately without waiting for a clock edge.
REQ-031 Reset asserted mid-count or mid-adjust SHALL discard any pending step.
REQ-032 Counting resumes from 00:00 on the first rising edge after rst deasserts, with divider phase restarting at 0.

Verification (CLK_FREQ=1000)
REQ-033 Reset released, run=1, down=0:
- tick_500hz every 2 cycles, tick_2hz every 500 cycles, tick_1hz every 1000 cycles;
- sec0 reaches 1 after 1000 cycles.
REQ-034 Preload 00:59 via adjust, then run up:
- next tick_1hz gives 01:00 in one edge;
- from 59:59 the next tick gives 00:00 with wrap pulsing for exactly 1 cycle.
REQ-035 From 00:00, run down:
- first tick gives 59:59 with wrap=1;
- from 10:00 the next tick gives 09:59.
REQ-036 run=0 for 3000 cycles: digits and tick_1hz frozen, tick_500hz still pulsing; run=1 resumes with the 1 Hz phase preserved.
REQ-037 adj=1, sel=01, sec1=5, one inc -> sec1=0, min0 unchanged, wrap=0.
REQ-038 adj=1, sel=01, sec1=0, one dec -> sec1=5.
REQ-039 adj=1, sel=01, inc and dec asserted together -> no change.
REQ-040 rst pulsed between clock edges at 12:34 -> all outputs 0 before the next edge.
